// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the frame DRAM writer/reader path.
package frame_pkg;

   localparam int D_WIDTH     = 8;
   localparam int A_WIDTH     = 21;
   localparam int FRAME_BYTES = 921600;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/frame_writer_if.sv
// Pixel stream input plus DRAM write port of the frame writer.
// Handshake: a byte moves on a cycle where in_valid && in_ready; in_valid and in_data stay put until then.
interface frame_writer_if #(
   parameter int D_WIDTH = frame_pkg::D_WIDTH,
   parameter int A_WIDTH = frame_pkg::A_WIDTH
);

   logic               in_valid;
   logic [D_WIDTH-1:0] in_data;
   logic               in_ready;
   logic               rd_busy;
   logic               wen;
   logic [A_WIDTH-1:0] waddr;
   logic [D_WIDTH-1:0] wdata;

   modport master (
      output in_valid, in_data, rd_busy,
      input  in_ready, wen, waddr, wdata
   );

   modport slave (
      input  in_valid, in_data, rd_busy,
      output in_ready, wen, waddr, wdata
   );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered head; push and pop in one cycle are both honoured.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      full     = (count_q == (AW+1)'(DEPTH));
      empty    = (count_q == '0);
      head     = mem_q[rd_ptr_q];
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // Storage is cleared too so the head reads zero straight out of reset.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/frame_writer.sv
// Buffers the filtered pixel stream and writes one frame sequentially into the byte-wide DRAM,
// yielding to reads, then pulses writefile/done once the last byte has landed.
module frame_writer #(
   parameter int D_WIDTH     = frame_pkg::D_WIDTH,
   parameter int A_WIDTH     = frame_pkg::A_WIDTH,
   parameter int FRAME_BYTES = frame_pkg::FRAME_BYTES,
   parameter int BASE_ADDR   = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   frame_writer_if.slave         bus,
   output logic                  writefile,
   output logic                  busy,
   output logic                  done,
   output frame_pkg::state_t     dbg_state
);

   import frame_pkg::*;

   // One extra counter bit so a frame filling the whole address space still fits.
   localparam int             CW        = A_WIDTH + 1;
   localparam logic [CW-1:0]  FRAME_LEN = CW'(FRAME_BYTES);

   state_t            state_q, state_d;
   logic [CW-1:0]     acc_cnt_q, acc_cnt_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic              writefile_q, writefile_d;
   logic              push, pop;
   logic              fifo_full, fifo_empty;
   logic [D_WIDTH-1:0] fifo_head;
   logic              writing;

   sync_fifo #(
      .WIDTH (D_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (bus.in_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Write side is combinational so rd_busy steals the DRAM port in the very cycle it is raised.
   always_comb begin
      writing      = (state_q == RUN) || (state_q == DRAIN);
      bus.in_ready = (state_q == RUN) && !fifo_full && (acc_cnt_q < FRAME_LEN);
      push         = bus.in_valid && bus.in_ready;
      pop          = writing && !fifo_empty && !bus.rd_busy;
      bus.wen      = pop;
      bus.wdata    = fifo_head;
      bus.waddr    = A_WIDTH'(BASE_ADDR) + wr_cnt_q[A_WIDTH-1:0];
   end

   always_comb begin
      state_d   = state_q;
      acc_cnt_d = acc_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               acc_cnt_d = '0;
               wr_cnt_d  = '0;
            end
         end
         RUN, DRAIN: begin
            if (push) acc_cnt_d = acc_cnt_q + CW'(1);
            if (pop)  wr_cnt_d  = wr_cnt_q + CW'(1);
            // Finishing on the updated write count puts DONE in the cycle right after the last write.
            if (wr_cnt_d == FRAME_LEN) begin
               state_d = DONE;
            end else if (acc_cnt_d == FRAME_LEN) begin
               state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      writefile_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_cnt_q   <= '0;
         wr_cnt_q    <= '0;
         writefile_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_cnt_q   <= acc_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         writefile_q <= writefile_d;
      end
   end

   assign writefile = writefile_q;
   assign done      = writefile_q;
   assign busy      = writing;
   assign dbg_state = state_q;

endmodule
